// File: rtl/an_sec_decode_arbiter_if.sv
// Bus bundle between the requesters, the shared AN-code SEC decoder and the
// response consumer. The arbiter connects through the master modport.
interface an_sec_decode_arbiter_if #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned ID_BITS  = 2,
   parameter int unsigned W_BITS   = 36,
   parameter int unsigned N_BITS   = 29,
   parameter int unsigned CNT_BITS = 16
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*W_BITS-1:0] req_w;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      dec_start;
   logic [W_BITS-1:0]         dec_w;
   logic                      dec_done;
   logic [N_BITS-1:0]         dec_n;
   logic                      dec_corr;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [ID_BITS-1:0]        rsp_id;
   logic [N_BITS-1:0]         rsp_n;
   logic                      rsp_corr;
   logic                      rsp_tmo;
   logic [CNT_BITS-1:0]       corr_count;

   modport master (
      input  req_valid, req_w, dec_done, dec_n, dec_corr, rsp_ready,
      output req_ready, dec_start, dec_w, rsp_valid, rsp_id, rsp_n, rsp_corr, rsp_tmo,
             corr_count
   );

   modport slave (
      output req_valid, req_w, dec_done, dec_n, dec_corr, rsp_ready,
      input  req_ready, dec_start, dec_w, rsp_valid, rsp_id, rsp_n, rsp_corr, rsp_tmo,
             corr_count
   );
endinterface

// File: rtl/an_sec_decode_arbiter.sv
// Round-robin arbiter sharing one AN-code (A=83) SEC decoder among NUM_REQ
// requesters. One job in flight: grant, start decoder, wait (with timeout),
// then hold the response until the consumer accepts it.
module an_sec_decode_arbiter #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned ID_BITS  = 2,
   parameter int unsigned W_BITS   = 36,
   parameter int unsigned N_BITS   = 29,
   parameter int unsigned TMO      = 15,
   parameter int unsigned CNT_BITS = 16
) (
   input logic                   clk,
   input logic                   rst_n,
   an_sec_decode_arbiter_if.master bus
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_t;

   state_t              state_q;
   logic [ID_BITS-1:0]  rr_ptr_q;
   logic [ID_BITS-1:0]  id_q;
   logic [W_BITS-1:0]   dec_w_q;
   logic                dec_start_q;
   logic                rsp_valid_q;
   logic [N_BITS-1:0]   rsp_n_q;
   logic                rsp_corr_q;
   logic                rsp_tmo_q;
   logic [CNT_BITS-1:0] corr_count_q;
   logic [7:0]          wait_cnt_q;

   logic [W_BITS-1:0]   req_words [NUM_REQ];
   logic [ID_BITS:0]    scan;
   logic [ID_BITS-1:0]  win_idx;
   logic                win_found;
   logic [NUM_REQ-1:0]  grant;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
      assign req_words[g] = bus.req_w[g*W_BITS +: W_BITS];
   end

   // Pick the first valid requester scanning upward from rr_ptr, wrapping mod NUM_REQ.
   always_comb begin
      scan      = '0;
      win_idx   = '0;
      win_found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan = {1'b0, rr_ptr_q} + (ID_BITS+1)'(k);
         if (scan >= (ID_BITS+1)'(NUM_REQ)) begin
            scan = scan - (ID_BITS+1)'(NUM_REQ);
         end
         if (!win_found && bus.req_valid[scan[ID_BITS-1:0]]) begin
            win_found = 1'b1;
            win_idx   = scan[ID_BITS-1:0];
         end
      end
   end

   // One-hot grant, only offered while idle.
   always_comb begin
      grant = '0;
      if (state_q == StIdle && win_found) begin
         grant[win_idx] = 1'b1;
      end
   end

   // Transaction FSM; every output except the grant comes straight from a register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         rr_ptr_q     <= '0;
         id_q         <= '0;
         dec_w_q      <= '0;
         dec_start_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_n_q      <= '0;
         rsp_corr_q   <= 1'b0;
         rsp_tmo_q    <= 1'b0;
         corr_count_q <= '0;
         wait_cnt_q   <= '0;
      end else begin
         dec_start_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (win_found) begin
                  dec_w_q     <= req_words[win_idx];
                  id_q        <= win_idx;
                  dec_start_q <= 1'b1;
                  state_q     <= StIssue;
               end
            end
            StIssue: begin
               wait_cnt_q <= '0;
               state_q    <= StWait;
            end
            StWait: begin
               wait_cnt_q <= wait_cnt_q + 8'd1;
               // A completion on the timeout cycle still counts as a real result.
               if (bus.dec_done) begin
                  rsp_n_q     <= bus.dec_n;
                  rsp_corr_q  <= bus.dec_corr;
                  rsp_tmo_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= StResp;
               end else if (wait_cnt_q == 8'(TMO - 1)) begin
                  rsp_n_q     <= '0;
                  rsp_corr_q  <= 1'b0;
                  rsp_tmo_q   <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  state_q     <= StResp;
               end
            end
            StResp: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  rr_ptr_q    <= (id_q == ID_BITS'(NUM_REQ - 1)) ? '0 : id_q + ID_BITS'(1);
                  if (rsp_corr_q && (corr_count_q != '1)) begin
                     corr_count_q <= corr_count_q + CNT_BITS'(1);
                  end
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.req_ready  = grant;
   assign bus.dec_start  = dec_start_q;
   assign bus.dec_w      = dec_w_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = id_q;
   assign bus.rsp_n      = rsp_n_q;
   assign bus.rsp_corr   = rsp_corr_q;
   assign bus.rsp_tmo    = rsp_tmo_q;
   assign bus.corr_count = corr_count_q;

endmodule

// File: tb/tb_an_sec_decode_arbiter.sv
// Bench for an_sec_decode_arbiter: directed scenarios followed by random
// transactions, checked against a behavioural arbiter/decoder model.
module tb_an_sec_decode_arbiter;

   localparam int NUM_REQ  = 4;
   localparam int TMO      = 15;
   localparam int CNT_BITS = 4;
   localparam int CNT_MAX  = (1 << CNT_BITS) - 1;

   logic clk;
   logic rst_n;

   an_sec_decode_arbiter_if #(
      .NUM_REQ(NUM_REQ), .ID_BITS(2), .W_BITS(36), .N_BITS(29), .CNT_BITS(CNT_BITS)
   ) bus ();

   an_sec_decode_arbiter #(
      .NUM_REQ(NUM_REQ), .ID_BITS(2), .W_BITS(36), .N_BITS(29), .TMO(TMO),
      .CNT_BITS(CNT_BITS)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: next round-robin start and corrected-response count.
   int          rr_m  = 0;
   int          cnt_m = 0;
   logic [35:0] words [NUM_REQ];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Nearest multiple of 83 gives N; any nonzero residue means a correction.
   task automatic dec_model(input logic [35:0] w, output logic [28:0] n, output logic c);
      longint q;
      q = (longint'(w) + 41) / 83;
      n = 29'(q);
      c = (longint'(w) % 83) != 0;
   endtask

   function automatic int exp_win(input logic [NUM_REQ-1:0] v);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (v[(rr_m + k) % NUM_REQ]) return (rr_m + k) % NUM_REQ;
      end
      return -1;
   endfunction

   // err_mode: 0 clean, 1 always a single +-2^k error, 2 random choice.
   function automatic logic [35:0] rand_word(input int err_mode);
      longint n, e;
      bit     use_err;
      n       = longint'($urandom_range(32'h1FFF_FFF0, 64));
      use_err = (err_mode == 1) || (err_mode == 2 && $urandom_range(1, 0) == 1);
      e       = use_err ? (longint'(1) << $urandom_range(5, 0)) : 0;
      if (use_err && $urandom_range(1, 0) == 1) e = -e;
      return 36'(83 * n + e);
   endfunction

   function automatic logic [NUM_REQ*36-1:0] pack_words();
      logic [NUM_REQ*36-1:0] p;
      for (int i = 0; i < NUM_REQ; i++) p[i*36 +: 36] = words[i];
      return p;
   endfunction

   // One full transaction starting at a negedge in IDLE. lat = WAIT cycle on
   // which dec_done pulses (0 = never, forcing a timeout); bp = stalled RESP cycles.
   task automatic txn(input logic [NUM_REQ-1:0] vmask, input int lat, input int bp);
      int          w;
      int          rsp_at;
      bit          tmo;
      logic [28:0] en;
      logic        ec;
      logic [28:0] exp_n;
      bus.req_w     = pack_words();
      bus.req_valid = vmask;
      bus.rsp_ready = 1'b0;
      #1;
      w = exp_win(vmask);
      chk("grant", bus.req_ready, 64'(1) << w);
      @(negedge clk);
      chk("dec_start", bus.dec_start, 1);
      chk("dec_w", bus.dec_w, words[w]);
      chk("ready_issue", bus.req_ready, 0);
      bus.req_valid = '0;
      dec_model(words[w], en, ec);
      tmo    = (lat == 0);
      rsp_at = tmo ? TMO + 1 : lat + 1;
      exp_n  = tmo ? 29'd0 : en;
      for (int k = 1; k < rsp_at; k++) begin
         @(negedge clk);
         chk("no_rsp_yet", bus.rsp_valid, 0);
         if (k == 1) chk("start_pulse", bus.dec_start, 0);
         bus.dec_done = (k == lat);
         bus.dec_n    = (k == lat) ? en : 29'($urandom);
         bus.dec_corr = (k == lat) ? ec : 1'($urandom);
      end
      @(negedge clk);
      bus.dec_done = 1'b0;
      chk("rsp_valid", bus.rsp_valid, 1);
      chk("rsp_id", bus.rsp_id, w);
      chk("rsp_n", bus.rsp_n, exp_n);
      chk("rsp_corr", bus.rsp_corr, tmo ? 1'b0 : ec);
      chk("rsp_tmo", bus.rsp_tmo, tmo);
      for (int b = 0; b < bp; b++) begin
         bus.req_valid = vmask;
         bus.dec_done  = (b == 0);
         bus.dec_n     = ~en;
         #1;
         chk("bp_ready", bus.req_ready, 0);
         @(negedge clk);
         chk("bp_valid", bus.rsp_valid, 1);
         chk("bp_n", bus.rsp_n, exp_n);
         chk("bp_start", bus.dec_start, 0);
      end
      bus.dec_done  = 1'b0;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk("rsp_drop", bus.rsp_valid, 0);
      rr_m = (w + 1) % NUM_REQ;
      if (!tmo && ec && cnt_m < CNT_MAX) cnt_m++;
      chk("corr_count", bus.corr_count, cnt_m);
   endtask

   task automatic check_reset_outputs();
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_start", bus.dec_start, 0);
      chk("rst_dec_w", bus.dec_w, 0);
      chk("rst_valid", bus.rsp_valid, 0);
      chk("rst_id", bus.rsp_id, 0);
      chk("rst_n", bus.rsp_n, 0);
      chk("rst_corr", bus.rsp_corr, 0);
      chk("rst_tmo", bus.rsp_tmo, 0);
      chk("rst_count", bus.corr_count, 0);
   endtask

   initial begin
      logic [NUM_REQ-1:0] m;
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_w     = '0;
      bus.dec_done  = 1'b0;
      bus.dec_n     = '0;
      bus.dec_corr  = 1'b0;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) words[i] = rand_word(0);
      #1;
      check_reset_outputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single clean request, then a corrected one from requester 2.
      words[0] = 36'd83000;
      txn(4'b0001, 5, 0);
      words[2] = 36'd83004;
      txn(4'b0100, 3, 0);

      // Round robin with everyone asking, then 1 and 3 contending.
      for (int i = 0; i < 5; i++) txn(4'b1111, 2, 0);
      txn(4'b0010, 2, 0);
      txn(4'b1010, 2, 0);

      // Timeout, and completion exactly on the timeout cycle.
      txn(4'b0100, 0, 0);
      words[1] = rand_word(1);
      txn(4'b0010, TMO, 0);

      // Backpressure with stale dec_done pulses while held.
      words[3] = rand_word(1);
      txn(4'b1000, 4, 10);

      // Reset in WAIT, then a late completion that must be ignored.
      bus.req_w     = pack_words();
      bus.req_valid = 4'b0010;
      @(negedge clk);
      bus.req_valid = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst_n        = 1'b1;
      bus.dec_done = 1'b1;
      bus.dec_n    = 29'h155;
      bus.dec_corr = 1'b1;
      @(negedge clk);
      bus.dec_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("late_done_valid", bus.rsp_valid, 0);
         chk("late_done_start", bus.dec_start, 0);
      end
      rr_m  = 0;
      cnt_m = 0;

      // Saturate the corrected-response counter.
      for (int i = 0; i < CNT_MAX + 2; i++) begin
         for (int j = 0; j < NUM_REQ; j++) words[j] = rand_word(1);
         m = 4'($urandom_range(15, 1));
         txn(m, $urandom_range(TMO, 1), 0);
      end
      chk("count_saturated", bus.corr_count, CNT_MAX);

      // Random traffic.
      for (int i = 0; i < 40; i++) begin
         for (int j = 0; j < NUM_REQ; j++) words[j] = rand_word(2);
         m = 4'($urandom_range(15, 1));
         txn(m, $urandom_range(TMO, 0), $urandom_range(3, 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
